// File: rtl/i2c_apb_pkg.sv
// Shared register map, STATUS bit positions and sequencer state encoding
// for the APB-driven I2C transfer sequencer.
package i2c_apb_pkg;

  localparam int REG_PRESCALE = 2;
  localparam int REG_STATUS   = 3;
  localparam int REG_COMMAND  = 4;
  localparam int REG_RX       = 5;
  localparam int REG_TX       = 6;

  localparam int ST_BUSY     = 0;
  localparam int ST_TX_FULL  = 1;
  localparam int ST_RX_EMPTY = 2;
  localparam int ST_NACK     = 3;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CMD,
    S_TXPOLL,
    S_TXWR,
    S_RXPOLL,
    S_RXRD,
    S_BUSYPOLL
  } seq_state_t;

endpackage

// File: rtl/apb_master_port.sv
// Single-outstanding APB master: SETUP then ACCESS until pready, with
// address/data held from SETUP to completion.
module apb_master_port #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              i_start,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_idle,
  output logic              o_done,
  output logic [DATA_W-1:0] o_rdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;

  // A new start is only taken while the bus is idle, so there is always one
  // idle cycle between back-to-back accesses.
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
    end else if (!r_psel) begin
      if (i_start) begin
        r_psel   <= 1'b1;
        r_pwrite <= i_write;
        r_paddr  <= i_addr;
        r_pwdata <= i_wdata;
      end
    end else if (!r_penable) begin
      r_penable <= 1'b1;
    end else if (pready) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end
  end

  assign o_idle  = !r_psel;
  assign o_done  = r_psel & r_penable & pready;
  assign o_rdata = prdata;
  assign psel    = r_psel;
  assign penable = r_penable;
  assign pwrite  = r_pwrite;
  assign paddr   = r_paddr;
  assign pwdata  = r_pwdata;

endmodule

// File: rtl/i2c_apb_sequencer.sv
// Runs complete I2C transfers by sequencing PRESCALE/COMMAND/STATUS/TX/RX
// accesses on the I2C core's APB port, one access at a time.
module i2c_apb_sequencer
  import i2c_apb_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter int          DATA_W   = 8,
  parameter int          LEN_W    = 4,
  parameter logic [7:0]  PRESCALE = 8'd99,
  parameter int          TMO_W    = 10
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [6:0]        req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              done,
  output logic              err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((2**TMO_W) - 2);

  seq_state_t        r_state, w_nxt;
  logic              r_rw;
  logic [6:0]        r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_err;
  logic [TMO_W-1:0]  r_tmo;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;

  logic              w_start, w_wr;
  logic [ADDR_W-1:0] w_paddr;
  logic [DATA_W-1:0] w_pwdata;
  logic              w_idle, w_xdone;
  logic [DATA_W-1:0] w_rdata;
  logic              w_accept, w_cnt_inc, w_err_set, w_tmo_clr, w_tmo_inc;
  logic              w_rx_cap, w_done, w_tx_rdy;
  logic              w_last, w_tmo_hit;

  apb_master_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_apb (
    .pclk    (pclk),
    .presetn (presetn),
    .i_start (w_start),
    .i_write (w_wr),
    .i_addr  (w_paddr),
    .i_wdata (w_pwdata),
    .o_idle  (w_idle),
    .o_done  (w_xdone),
    .o_rdata (w_rdata),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready)
  );

  assign w_last    = (r_cnt == r_len);
  // r_tmo counts failed reads already taken; this read is the final allowed one.
  assign w_tmo_hit = (r_tmo == TMO_LAST);

  always_ff @(posedge pclk) begin
    if (!presetn) r_state <= S_INIT;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_start   = 1'b0;
    w_wr      = 1'b0;
    w_paddr   = ADDR_W'(REG_STATUS);
    w_pwdata  = '0;
    w_accept  = 1'b0;
    w_cnt_inc = 1'b0;
    w_err_set = 1'b0;
    w_tmo_clr = 1'b0;
    w_tmo_inc = 1'b0;
    w_rx_cap  = 1'b0;
    w_done    = 1'b0;
    w_tx_rdy  = 1'b0;
    case (r_state)
      S_INIT: begin
        w_start  = w_idle;
        w_wr     = 1'b1;
        w_paddr  = ADDR_W'(REG_PRESCALE);
        w_pwdata = DATA_W'(PRESCALE);
        if (w_xdone) w_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          w_nxt    = S_CMD;
        end
      end
      S_CMD: begin
        w_start  = w_idle;
        w_wr     = 1'b1;
        w_paddr  = ADDR_W'(REG_COMMAND);
        w_pwdata = DATA_W'({r_addr, r_rw});
        if (w_xdone) begin
          w_tmo_clr = 1'b1;
          w_nxt     = r_rw ? S_RXPOLL : S_TXPOLL;
        end
      end
      S_TXPOLL: begin
        // No STATUS read until the host has a byte, so a host stall never times out.
        w_start = w_idle & tx_valid;
        if (w_xdone) begin
          if (w_rdata[ST_NACK]) begin
            w_err_set = 1'b1;
            w_tmo_clr = 1'b1;
            w_nxt     = S_BUSYPOLL;
          end else if (!w_rdata[ST_TX_FULL]) begin
            w_nxt = S_TXWR;
          end else if (w_tmo_hit) begin
            w_err_set = 1'b1;
            w_done    = 1'b1;
            w_nxt     = S_IDLE;
          end else begin
            w_tmo_inc = 1'b1;
          end
        end
      end
      S_TXWR: begin
        w_start  = w_idle;
        w_wr     = 1'b1;
        w_paddr  = ADDR_W'(REG_TX);
        w_pwdata = tx_data;
        if (w_xdone) begin
          w_tx_rdy  = 1'b1;
          w_tmo_clr = 1'b1;
          w_cnt_inc = !w_last;
          w_nxt     = w_last ? S_BUSYPOLL : S_TXPOLL;
        end
      end
      S_RXPOLL: begin
        w_start = w_idle;
        if (w_xdone) begin
          if (w_rdata[ST_NACK]) begin
            w_err_set = 1'b1;
            w_tmo_clr = 1'b1;
            w_nxt     = S_BUSYPOLL;
          end else if (!w_rdata[ST_RX_EMPTY]) begin
            w_nxt = S_RXRD;
          end else if (w_tmo_hit) begin
            w_err_set = 1'b1;
            w_done    = 1'b1;
            w_nxt     = S_IDLE;
          end else begin
            w_tmo_inc = 1'b1;
          end
        end
      end
      S_RXRD: begin
        w_start = w_idle;
        w_paddr = ADDR_W'(REG_RX);
        if (w_xdone) begin
          w_rx_cap  = 1'b1;
          w_tmo_clr = 1'b1;
          w_cnt_inc = !w_last;
          w_nxt     = w_last ? S_BUSYPOLL : S_RXPOLL;
        end
      end
      S_BUSYPOLL: begin
        w_start = w_idle;
        if (w_xdone) begin
          if (w_rdata[ST_NACK]) w_err_set = 1'b1;
          if (!w_rdata[ST_BUSY]) begin
            w_done = 1'b1;
            w_nxt  = S_IDLE;
          end else if (w_tmo_hit) begin
            w_err_set = 1'b1;
            w_done    = 1'b1;
            w_nxt     = S_IDLE;
          end else begin
            w_tmo_inc = 1'b1;
          end
        end
      end
      default: w_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      r_rw       <= 1'b0;
      r_addr     <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_tmo      <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= w_rx_cap;
      if (w_rx_cap) r_rx_data <= w_rdata;
      if (w_accept) begin
        r_rw   <= req_rw;
        r_addr <= req_addr;
        r_len  <= req_len;
        r_cnt  <= '0;
        r_err  <= 1'b0;
      end else begin
        if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
        if (w_err_set) r_err <= 1'b1;
      end
      if (w_tmo_clr)      r_tmo <= '0;
      else if (w_tmo_inc) r_tmo <= r_tmo + 1'b1;
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign tx_ready  = w_tx_rdy;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign done      = w_done;
  assign err       = w_done & (r_err | w_err_set);

endmodule

// File: tb/tb_i2c_apb_sequencer.sv
// Bench for i2c_apb_sequencer: scripted I2C-core STATUS responses, an access
// log compared against a transfer-level expectation, plus hand corner cases.
module tb_i2c_apb_sequencer;

  localparam int LEN_W = 4;
  localparam int TMO_W = 3;

  logic             pclk = 1'b0;
  logic             presetn = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_rw = 1'b0;
  logic [6:0]       req_addr = '0;
  logic [LEN_W-1:0] req_len = '0;
  logic [7:0]       tx_data = '0;
  logic             tx_valid = 1'b0;
  logic             tx_ready;
  logic [7:0]       rx_data;
  logic             rx_valid, done, err;
  logic             psel, penable, pwrite;
  logic [7:0]       paddr, pwdata;
  logic [7:0]       prdata = '0;
  logic             pready = 1'b0;

  i2c_apb_sequencer #(.ADDR_W(8), .DATA_W(8), .LEN_W(LEN_W), .PRESCALE(8'd99), .TMO_W(TMO_W)) u_dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_addr(req_addr), .req_len(req_len),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .done(done), .err(err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit         rw;
    logic [6:0] addr;
    int         len;
    int         stall;
    int         nack_at;
    int         busy_n;
    logic [7:0] dbase;
    bit         exp_err;
    int         exp_bytes;
    int         exp_status;
  } vec_t;

  logic [7:0]  st_q[$], rx_src_q[$], tx_q[$], rx_got_q[$], exp_rx_q[$];
  logic [16:0] log_q[$], exp_q[$];
  int n_chk = 0, n_pass = 0;
  int wmax = 0, cmd_wait = -1, wcnt = 0;
  int txr_cnt = 0, done_cnt = 0, last_err = 0, run4 = 0, max4 = 0;
  bit gate_en = 1'b0;

  function automatic logic [16:0] ent(input logic w, input logic [7:0] a, input logic [7:0] d);
    return {w, a, d};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // I2C core model: answers STATUS from the script, RX_DATA from the byte source.
  always @(posedge pclk) begin
    #1;
    pready = 1'b0;
    prdata = '0;
    if (!presetn) wcnt = 0;
    else if (psel && !penable) wcnt = (paddr == 8'd4 && cmd_wait >= 0) ? cmd_wait : int'($urandom_range(0, wmax));
    else if (psel && penable) begin
      if (wcnt == 0) begin
        pready = 1'b1;
        if (!pwrite) begin
          if (paddr == 8'd3 && st_q.size() > 0) prdata = st_q.pop_front();
          else if (paddr == 8'd5 && rx_src_q.size() > 0) prdata = rx_src_q.pop_front();
        end
        log_q.push_back(ent(pwrite, paddr, pwrite ? pwdata : prdata));
      end else wcnt--;
    end
  end

  always @(posedge pclk) begin
    #1;
    tx_valid = (tx_q.size() > 0) && (!gate_en || ($urandom_range(0, 3) != 0));
    tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
  end

  always @(negedge pclk) begin
    if (presetn) begin
      if (tx_ready) begin
        txr_cnt++;
        if (tx_q.size() > 0) void'(tx_q.pop_front());
      end
      if (rx_valid) rx_got_q.push_back(rx_data);
      if (done) begin
        done_cnt++;
        last_err = int'(err);
      end
    end
    if (psel && penable && paddr == 8'd4) run4++;
    else begin
      if (run4 > max4) max4 = run4;
      run4 = 0;
    end
  end

  function automatic int count_status(input logic [16:0] q[$]);
    int c = 0;
    foreach (q[i]) if (!q[i][16] && q[i][15:8] == 8'd3) c++;
    return c;
  endfunction

  task automatic issue(input bit rw, input logic [6:0] addr, input int len);
    int n = 0;
    while (!req_ready && n < 100) begin @(negedge pclk); #1; n++; end
    check("req_ready before request", int'(req_ready), 1);
    @(posedge pclk); #1;
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_len = LEN_W'(len);
    @(posedge pclk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin @(negedge pclk); #1; n++; end
    check({tag, " done pulse"}, done_cnt - d0, 1);
  endtask

  // Expected access log derived from the transfer description alone.
  task automatic run_xfer(input vec_t v, input bit use_tab, input string tag);
    int moved = 0;
    bit nacked = 1'b0;
    logic [7:0] b, sv;
    int d0, nmin;
    st_q.delete(); rx_src_q.delete(); tx_q.delete(); exp_q.delete(); exp_rx_q.delete(); rx_got_q.delete();
    txr_cnt = 0;
    exp_q.push_back(ent(1'b1, 8'd4, {v.addr, v.rw}));
    for (int i = 0; i <= v.len; i++) begin
      b = use_tab ? v.dbase + 8'(i) : 8'($urandom);
      if (i == v.nack_at) begin
        if (!v.rw) tx_q.push_back(b);
        st_q.push_back(8'h09); exp_q.push_back(ent(1'b0, 8'd3, 8'h09));
        nacked = 1'b1;
        break;
      end
      sv = v.rw ? 8'h05 : 8'h03;
      for (int s = 0; s < v.stall; s++) begin st_q.push_back(sv); exp_q.push_back(ent(1'b0, 8'd3, sv)); end
      st_q.push_back(8'h01); exp_q.push_back(ent(1'b0, 8'd3, 8'h01));
      if (v.rw) begin rx_src_q.push_back(b); exp_rx_q.push_back(b); exp_q.push_back(ent(1'b0, 8'd5, b)); end
      else begin tx_q.push_back(b); exp_q.push_back(ent(1'b1, 8'd6, b)); end
      moved++;
    end
    for (int s = 0; s < v.busy_n; s++) begin st_q.push_back(8'h01); exp_q.push_back(ent(1'b0, 8'd3, 8'h01)); end
    st_q.push_back(8'h00); exp_q.push_back(ent(1'b0, 8'd3, 8'h00));
    log_q.delete();
    d0 = done_cnt;
    issue(v.rw, v.addr, v.len);
    wait_done(d0, tag);
    check({tag, " err"}, last_err, use_tab ? int'(v.exp_err) : int'(nacked));
    check({tag, " bytes"}, v.rw ? rx_got_q.size() : txr_cnt, use_tab ? v.exp_bytes : moved);
    if (use_tab) check({tag, " status reads"}, count_status(log_q), v.exp_status);
    check({tag, " apb access count"}, log_q.size(), exp_q.size());
    nmin = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) check({tag, $sformatf(" apb access %0d", i)}, int'(log_q[i]), int'(exp_q[i]));
    if (v.rw) begin
      nmin = (rx_got_q.size() < exp_rx_q.size()) ? rx_got_q.size() : exp_rx_q.size();
      for (int i = 0; i < nmin; i++) check({tag, $sformatf(" rx byte %0d", i)}, int'(rx_got_q[i]), int'(exp_rx_q[i]));
    end
    @(negedge pclk); #1;
    check({tag, " req_ready after done"}, int'(req_ready), 1);
    check({tag, " done single cycle"}, int'(done), 0);
  endtask

  vec_t vt[7];
  vec_t rv;

  initial begin
    int n, d0, ntx, nst;
    vt[0] = '{1'b0, 7'h50,  2, 0, -1, 0, 8'hA1, 1'b0,  3,  4};
    vt[1] = '{1'b1, 7'h50,  1, 2, -1, 0, 8'h5C, 1'b0,  2,  7};
    vt[2] = '{1'b0, 7'h50,  2, 0,  1, 0, 8'hA1, 1'b1,  1,  3};
    vt[3] = '{1'b1, 7'h13,  0, 1, -1, 2, 8'h7E, 1'b0,  1,  5};
    vt[4] = '{1'b0, 7'h7F, 15, 0, -1, 0, 8'h10, 1'b0, 16, 17};
    vt[5] = '{1'b1, 7'h00,  3, 1,  0, 1, 8'h00, 1'b1,  0,  3};
    vt[6] = '{1'b0, 7'h2A,  1, 6, -1, 0, 8'hC0, 1'b0,  2, 15};

    // Reset state, then the PRESCALE write as the first access.
    presetn = 1'b0;
    repeat (3) @(negedge pclk);
    #1;
    check("reset psel", int'(psel), 0);
    check("reset penable", int'(penable), 0);
    check("reset req_ready", int'(req_ready), 0);
    check("reset done", int'(done), 0);
    check("reset rx_valid", int'(rx_valid), 0);
    check("reset paddr", int'(paddr), 0);
    @(posedge pclk); #1;
    presetn = 1'b1;
    n = 0;
    while (!psel && n < 20) begin @(negedge pclk); #1; n++; end
    check("prescale setup psel", int'(psel), 1);
    check("prescale setup penable", int'(penable), 0);
    check("prescale paddr", int'(paddr), 2);
    check("prescale pwdata", int'(pwdata), 99);
    check("prescale pwrite", int'(pwrite), 1);
    @(negedge pclk); #1;
    check("prescale access penable", int'(penable), 1);
    @(negedge pclk); #1;
    check("prescale psel drop", int'(psel), 0);
    check("idle req_ready", int'(req_ready), 1);

    foreach (vt[i]) run_xfer(vt[i], 1'b1, $sformatf("vec%0d", i));

    // COMMAND write stretched by five wait cycles.
    max4 = 0; run4 = 0; cmd_wait = 5;
    run_xfer(vt[0], 1'b1, "stretch");
    cmd_wait = -1;
    check("stretch command access cycles", max4, 6);

    // busy never clears: BUSYPOLL gives up after 2**TMO_W-1 reads.
    st_q.delete(); tx_q.delete(); log_q.delete();
    st_q.push_back(8'h00);
    for (int i = 0; i < 20; i++) st_q.push_back(8'h01);
    tx_q.push_back(8'h33);
    d0 = done_cnt;
    issue(1'b0, 7'h22, 0);
    wait_done(d0, "timeout");
    check("timeout err", last_err, 1);
    ntx = -1; nst = 0;
    foreach (log_q[i]) begin
      if (log_q[i][16] && log_q[i][15:8] == 8'd6) ntx = i;
      else if (ntx >= 0 && !log_q[i][16] && log_q[i][15:8] == 8'd3) nst++;
    end
    check("timeout status reads after tx", nst, 7);
    @(negedge pclk); #1;
    check("timeout req_ready after done", int'(req_ready), 1);
    st_q.delete();

    // Randomized transfers with bus wait states and host tx_valid gaps.
    wmax = 2; gate_en = 1'b1;
    for (int k = 0; k < 25; k++) begin
      rv.rw      = 1'($urandom_range(0, 1));
      rv.addr    = 7'($urandom);
      rv.len     = int'($urandom_range(0, 7));
      rv.stall   = int'($urandom_range(0, 3));
      rv.busy_n  = int'($urandom_range(0, 3));
      rv.nack_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rv.len)) : -1;
      rv.dbase   = 8'h00;
      rv.exp_err = 1'b0; rv.exp_bytes = 0; rv.exp_status = 0;
      run_xfer(rv, 1'b0, $sformatf("rand%0d", k));
    end
    wmax = 0; gate_en = 1'b0;

    // Reset while a TX_DATA write is on the bus.
    st_q.delete(); tx_q.delete();
    tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33);
    d0 = done_cnt;
    issue(1'b0, 7'h50, 2);
    n = 0;
    while (!(psel && paddr == 8'd6) && n < 200) begin @(negedge pclk); #1; n++; end
    check("reached tx_data write", int'(psel && paddr == 8'd6), 1);
    presetn = 1'b0;
    @(negedge pclk); #1;
    check("reset mid-xfer psel", int'(psel), 0);
    check("reset mid-xfer req_ready", int'(req_ready), 0);
    check("reset mid-xfer no done", done_cnt - d0, 0);
    tx_q.delete(); st_q.delete();
    @(posedge pclk); #1;
    presetn = 1'b1;
    n = 0;
    while (!psel && n < 20) begin @(negedge pclk); #1; n++; end
    check("re-prescale paddr", int'(paddr), 2);
    check("re-prescale pwdata", int'(pwdata), 99);
    check("re-prescale pwrite", int'(pwrite), 1);
    repeat (4) @(negedge pclk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
